i2s_rx: RTL and testbench

//  I2S receiver (Philips format): deserialises stereo samples from an external ADC/codec

---
 rtl/i2s_rx.sv | 134 +++++++++++++
 tb/tb_i2s_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S (Philips) receiver, bclk domain.
// Deserialises stereo pairs and hands them out over valid/ready.
module i2s_rx #(
  parameter int BITSIZE  = 24,
  parameter int SLOTBITS = 32
) (
  input  logic               bclk,
  input  logic               rst,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               locked,
  output logic               frame_err,
  output logic               overrun,
  input  logic               err_clr
);

  localparam int PW = $clog2(2*SLOTBITS) + 1;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q;
  logic               lrclk_q;
  logic [PW-1:0]      pos_q;
  logic [BITSIZE-1:0] sreg_q;
  logic [BITSIZE-1:0] lhold_q;
  logic               lfresh_q;

  logic lr_edge_d;
  logic full_d;
  logic cap_d;
  logic run_d;
  logic pair_d;
  logic err_d;
  logic accept_d;
  logic load_d;

  assign lr_edge_d = lrclk ^ lrclk_q;
  assign full_d    = (pos_q == PW'(SLOTBITS-1));
  assign cap_d     = !lr_edge_d && (pos_q < PW'(BITSIZE));
  assign run_d     = (state_q == RUN);
  assign pair_d    = lr_edge_d && run_d && lrclk_q
                   && full_d && lfresh_q;
  assign err_d     = lr_edge_d && run_d && !full_d;
  assign accept_d  = out_valid && out_ready;
  assign load_d    = pair_d && (!out_valid || out_ready);

  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      state_q    <= SYNC;
      lrclk_q    <= 1'b0;
      pos_q      <= '0;
      sreg_q     <= '0;
      lhold_q    <= '0;
      lfresh_q   <= 1'b0;
      left_chan  <= '0;
      right_chan <= '0;
      out_valid  <= 1'b0;
      locked     <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      lrclk_q <= lrclk;

      if (lr_edge_d) begin
        pos_q <= '0;
      end else if (pos_q != '1) begin
        pos_q <= pos_q + 1'b1;
      end

      if (cap_d) begin
        sreg_q <= (sreg_q << 1) | BITSIZE'(sdata);
      end

      unique case (state_q)
        SYNC: begin
          lfresh_q <= 1'b0;
          if (lr_edge_d && !lrclk) begin
            state_q <= RUN;
            locked  <= 1'b1;
          end
        end
        RUN: begin
          if (lr_edge_d) begin
            if (!full_d) begin
              lfresh_q <= 1'b0;
              // a bad close on a falling edge relocks right here
              if (lrclk) begin
                state_q <= SYNC;
                locked  <= 1'b0;
              end
            end else if (!lrclk_q) begin
              lhold_q  <= sreg_q;
              lfresh_q <= 1'b1;
            end else begin
              lfresh_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= SYNC;
          locked  <= 1'b0;
        end
      endcase

      if (err_d) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end

      if (load_d) begin
        left_chan  <= lhold_q;
        right_chan <= sreg_q;
        out_valid  <= 1'b1;
      end else if (accept_d) begin
        out_valid <= 1'b0;
      end

      if (pair_d && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: bit-level I2S source, scoreboard
// of expected pairs, per-frame flag vectors.
module tb_i2s_rx;

  logic        bclk;
  logic        rst;
  logic        lrclk;
  logic        sdata;
  logic        out_ready;
  logic        err_clr;
  logic [23:0] left_chan;
  logic [23:0] right_chan;
  logic        out_valid;
  logic        locked;
  logic        frame_err;
  logic        overrun;

  logic        rdy16;
  logic [15:0] l16;
  logic [15:0] r16;
  logic        v16;
  logic        lk16;
  logic        fe16;
  logic        ov16;

  int n_vec;
  int n_bad;

  logic [47:0] sb_q[$];

  i2s_rx #(.BITSIZE(24), .SLOTBITS(32)) dut (
    .bclk       (bclk),
    .rst        (rst),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .left_chan  (left_chan),
    .right_chan (right_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .locked     (locked),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  i2s_rx #(.BITSIZE(16), .SLOTBITS(32)) dut16 (
    .bclk       (bclk),
    .rst        (rst),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .left_chan  (l16),
    .right_chan (r16),
    .out_valid  (v16),
    .out_ready  (rdy16),
    .locked     (lk16),
    .frame_err  (fe16),
    .overrun    (ov16),
    .err_clr    (err_clr)
  );

  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  task automatic chk(input string nm,
                     input logic [47:0] act,
                     input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // consumer side: a handshake happens on the next posedge
  initial begin
    forever begin
      @(negedge bclk);
      #1;
      if (rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pair", {left_chan, right_chan}, 48'h0);
        end else begin
          chk("pair", {left_chan, right_chan}, sb_q.pop_front());
        end
      end
    end
  end

  task automatic drive_bit(input logic c, input logic b);
    @(negedge bclk);
    lrclk = c;
    sdata = b;
  endtask

  task automatic slot(input logic c, input logic [23:0] d,
                      input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      drive_bit(c, (k >= 1 && k <= 24) ? d[24-k] : 1'b0);
    end
  endtask

  task automatic frame(input logic [23:0] l,
                       input logic [23:0] r);
    slot(1'b0, l, 0, 32);
    slot(1'b1, r, 0, 32);
  endtask

  task automatic settle();
    @(posedge bclk);
    #1;
  endtask

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          llen;
    int          rlen;
    bit          dlv;
    bit          ferr;
    bit          lck;
    bit          lmid;
    bit          c16;
  } vec_t;

  vec_t tv[12];

  initial begin
    tv[0]  = '{24'hA5A5A5, 24'h3C3C3C, 32, 32, 0, 0, 1, 0, 0};
    tv[1]  = '{24'hA5A5A5, 24'h3C3C3C, 32, 32, 1, 0, 1, 1, 0};
    tv[2]  = '{24'hA5A5A5, 24'h3C3C3C, 32, 32, 1, 0, 1, 1, 0};
    tv[3]  = '{24'h800000, 24'h000001, 32, 32, 1, 0, 1, 1, 0};
    tv[4]  = '{24'h7FFFFF, 24'hFFFFFF, 32, 32, 1, 0, 1, 1, 0};
    tv[5]  = '{24'h800000, 24'hFFFFFF, 32, 32, 1, 0, 1, 1, 0};
    tv[6]  = '{24'h7FFFFF, 24'h000001, 32, 32, 1, 0, 1, 1, 0};
    tv[7]  = '{24'hBEEF12, 24'h123456, 32, 32, 1, 0, 1, 1, 1};
    tv[8]  = '{24'h111111, 24'h222222, 32, 30, 0, 1, 1, 1, 0};
    tv[9]  = '{24'h333333, 24'h444444, 32, 32, 1, 1, 1, 1, 0};
    tv[10] = '{24'h555555, 24'h666666, 30, 32, 0, 1, 1, 0, 0};
    tv[11] = '{24'h777777, 24'h888888, 32, 32, 1, 1, 1, 1, 0};

    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    lrclk     = 1'b0;
    sdata     = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    rdy16     = 1'b1;

    repeat (3) settle();
    chk("rst_valid", 48'(out_valid), 48'h0);
    chk("rst_data", {left_chan, right_chan}, 48'h0);
    chk("rst_flags", 48'({locked, frame_err, overrun}), 48'h0);
    @(negedge bclk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (tv[i].dlv) sb_q.push_back({tv[i].l, tv[i].r});
      slot(1'b0, tv[i].l, 0, 1);
      settle();
      if (i > 0) begin
        chk($sformatf("v%0d_valid", i-1), 48'(out_valid),
            48'(tv[i-1].dlv));
        chk($sformatf("v%0d_ferr", i-1), 48'(frame_err),
            48'(tv[i-1].ferr));
        chk($sformatf("v%0d_lock", i-1), 48'(locked),
            48'(tv[i-1].lck));
        if (tv[i-1].c16) begin
          chk("bits16", {16'h0, l16, r16},
              {16'h0, tv[i-1].l[23:8], tv[i-1].r[23:8]});
        end
      end
      slot(1'b0, tv[i].l, 1, tv[i].llen);
      slot(1'b1, tv[i].r, 0, 2);
      settle();
      chk($sformatf("v%0d_lmid", i), 48'(locked),
          48'(tv[i].lmid));
      slot(1'b1, tv[i].r, 2, tv[i].rlen);
    end

    // back-pressure: A held, B dropped with overrun
    sb_q.push_back({24'hABCDEF, 24'hFEDCBA});
    slot(1'b0, 24'hABCDEF, 0, 1);
    settle();
    chk("v11_valid", 48'(out_valid), 48'h1);
    slot(1'b0, 24'hABCDEF, 1, 4);
    out_ready = 1'b0;
    slot(1'b0, 24'hABCDEF, 4, 32);
    slot(1'b1, 24'hFEDCBA, 0, 32);
    slot(1'b0, 24'h121212, 0, 1);
    settle();
    chk("hold_a", {left_chan, right_chan}, {24'hABCDEF, 24'hFEDCBA});
    chk("hold_ovr", 48'({out_valid, overrun}), 48'h2);
    slot(1'b0, 24'h121212, 1, 32);
    slot(1'b1, 24'h343434, 0, 32);
    slot(1'b0, 24'h565656, 0, 1);
    settle();
    chk("ovr_set", 48'({out_valid, overrun}), 48'h3);
    chk("ovr_hold", {left_chan, right_chan}, {24'hABCDEF, 24'hFEDCBA});
    drive_bit(1'b0, 1'b0);
    err_clr = 1'b1;
    drive_bit(1'b0, 1'b1);
    err_clr = 1'b0;
    settle();
    chk("clr_flags", 48'({frame_err, overrun}), 48'h0);
    chk("clr_hold", {left_chan, right_chan}, {24'hABCDEF, 24'hFEDCBA});
    out_ready = 1'b1;
    sb_q.push_back({24'h565656, 24'h787878});
    slot(1'b0, 24'h565656, 3, 32);
    slot(1'b1, 24'h787878, 0, 32);

    // reset mid right slot
    slot(1'b0, 24'h9A9A9A, 0, 32);
    slot(1'b1, 24'hBCBCBC, 0, 11);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_out", {left_chan, right_chan}, 48'h0);
    chk("mrst_flags", 48'({out_valid, locked, frame_err, overrun}),
        48'h0);
    slot(1'b1, 24'hBCBCBC, 11, 12);
    #2;
    rst = 1'b1;
    slot(1'b1, 24'hBCBCBC, 12, 32);
    settle();
    chk("mrst_lock", 48'({locked, out_valid}), 48'h0);
    sb_q.push_back({24'hDEDEDE, 24'hF0F0F0});
    frame(24'hDEDEDE, 24'hF0F0F0);
    sb_q.push_back({24'h0F0F0F, 24'h1E1E1E});
    frame(24'h0F0F0F, 24'h1E1E1E);
    slot(1'b0, 24'h2D2D2D, 0, 4);
    repeat (4) settle();
    chk("sb_empty", 48'(sb_q.size()), 48'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
